// File: rtl/spi_frame_slave.sv
// SPI slave front end: synchronises the SPI pins, decodes command + data frames into
// register-bank writes and serialises read data on MISO. Define SPI_STATUS_EN to shift a status byte out during the command phase.
module spi_frame_slave #(
  parameter int ADDR_W      = 4,
  parameter int REG_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_data_i,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_data_o_dv,
  input  logic [7:0]        status
);

  localparam int TX_W  = (REG_W > 8) ? REG_W : 8;
  localparam int CNT_W = $clog2(TX_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_cs_sync, r_clk_sync, r_mosi_sync;
  logic                   r_cs_d, r_sclk_d;
  logic                   w_cs, w_sclk, w_mosi;
  logic                   w_cs_fall, w_cs_rise, w_lead, w_trail;
  logic                   w_sample, w_shift, w_abort, w_last_cmd, w_last_data;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_W-1:0]      r_addr_sr, w_addr_shift;
  logic [REG_W-1:0]       r_data_sr, w_data_shift;
  logic [TX_W-1:0]        r_tx, w_tx_shl, w_tx_load, w_tx_start;
  logic                   r_wr, r_first, r_load;

  // cs_n syncs reset low so a select already held low at reset release is not seen as a fall
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cs_sync   <= '0;
      r_clk_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_d      <= 1'b0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], spi_clk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_d      <= w_cs;
      r_sclk_d    <= w_sclk;
    end
  end

  assign w_cs      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk    = r_clk_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_fall = r_cs_d & ~w_cs;
  assign w_cs_rise = ~r_cs_d & w_cs;
  assign w_lead    = (w_sclk != mode[1]) && (r_sclk_d == mode[1]);
  assign w_trail   = (w_sclk == mode[1]) && (r_sclk_d != mode[1]);
  assign w_sample  = mode[0] ? w_trail : w_lead;
  assign w_shift   = mode[0] ? w_lead : w_trail;
  assign w_abort   = !ena || w_cs_rise;

  assign w_last_cmd   = (r_state == S_CMD) && w_sample && (r_cnt == CNT_W'(7));
  assign w_last_data  = (r_state == S_DATA) && w_sample && (r_cnt == CNT_W'(REG_W - 1));
  assign w_addr_shift = ADDR_W'({r_addr_sr, w_mosi});
  assign w_data_shift = REG_W'({r_data_sr, w_mosi});
  assign w_tx_shl     = r_tx << 1;
  assign w_tx_load    = TX_W'(reg_data_i) << (TX_W - REG_W);

`ifdef SPI_STATUS_EN
  assign w_tx_start = TX_W'(status) << (TX_W - 8);
`else
  logic w_unused_status;
  assign w_unused_status = ^status;
  assign w_tx_start      = '0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cs_fall)   w_state_nxt = S_CMD;
      S_CMD:   if (w_last_cmd)  w_state_nxt = S_DATA;
      S_DATA:  if (w_last_data) w_state_nxt = S_DONE;
      default: w_state_nxt = r_state;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt         <= '0;
      r_addr_sr     <= '0;
      r_data_sr     <= '0;
      r_tx          <= '0;
      r_wr          <= 1'b0;
      r_first       <= 1'b0;
      r_load        <= 1'b0;
      spi_miso      <= 1'b0;
      reg_addr      <= '0;
      reg_data_o    <= '0;
      reg_data_o_dv <= 1'b0;
    end else begin
      reg_data_o_dv <= 1'b0;
      if (w_abort) begin
        r_cnt    <= '0;
        r_tx     <= '0;
        r_first  <= 1'b0;
        r_load   <= 1'b0;
        spi_miso <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cs_fall) begin
              r_cnt    <= '0;
              r_first  <= mode[0];
              r_load   <= 1'b0;
              r_tx     <= w_tx_start;
              spi_miso <= w_tx_start[TX_W-1];
            end
          end
          S_CMD: begin
            if (w_sample) begin
              r_addr_sr <= w_addr_shift;
              if (r_cnt == '0) r_wr <= w_mosi;
              if (w_last_cmd) begin
                reg_addr <= w_addr_shift;
                r_cnt    <= '0;
                r_load   <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else if (w_shift) begin
              // With CPHA=1 the first leading edge only presents the already-loaded MSB
              if (r_first) begin
                r_first <= 1'b0;
              end else begin
                r_tx     <= w_tx_shl;
                spi_miso <= w_tx_shl[TX_W-1];
              end
            end
          end
          S_DATA: begin
            if (w_sample) begin
              r_data_sr <= w_data_shift;
              if (w_last_data) begin
                r_cnt    <= '0;
                r_tx     <= '0;
                spi_miso <= 1'b0;
                if (r_wr) begin
                  reg_data_o    <= w_data_shift;
                  reg_data_o_dv <= 1'b1;
                end
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else if (w_shift) begin
              if (r_load) begin
                r_load   <= 1'b0;
                r_tx     <= w_tx_load;
                spi_miso <= w_tx_load[TX_W-1];
              end else begin
                r_tx     <= w_tx_shl;
                spi_miso <= w_tx_shl[TX_W-1];
              end
            end
          end
          default: spi_miso <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: bit-banged SPI master in all four modes,
// write/read frames, abort, enable gating and asynchronous reset mid-frame.
module tb_spi_frame_slave;

  localparam int HP = 8;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       ena = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       spi_cs_n = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [3:0] reg_addr;
  logic [7:0] reg_data_i = 8'h3C;
  logic [7:0] reg_data_o;
  logic       reg_data_o_dv;
  logic [7:0] status = 8'h5A;

`ifdef SPI_STATUS_EN
  localparam logic [7:0] EXP_ST = 8'h5A;
`else
  localparam logic [7:0] EXP_ST = 8'h00;
`endif

  spi_frame_slave #(.ADDR_W(4), .REG_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .reg_addr(reg_addr), .reg_data_i(reg_data_i), .reg_data_o(reg_data_o),
    .reg_data_o_dv(reg_data_o_dv), .status(status)
  );

  always #5 clk = ~clk;

  int         dv_total = 0;
  int         miso_hi = 0;
  logic [7:0] dv_data = 8'h00;
  always @(posedge clk) begin
    if (reg_data_o_dv) begin
      dv_total <= dv_total + 1;
      dv_data  <= reg_data_o;
    end
    if (spi_miso === 1'b1) miso_hi <= miso_hi + 1;
  end

  int          checks = 0;
  int          failures = 0;
  logic [15:0] rx;
  int          d0, m0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hp();
    repeat (HP) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [15:0] tx, input int nbits, input bit end_cs,
                      output logic [15:0] rxd);
    rxd = '0;
    spi_clk = mode[1];
    wait_hp();
    spi_cs_n = 1'b0;
    wait_hp();
    for (int i = 0; i < nbits; i++) begin
      if (!mode[0]) begin
        spi_mosi = tx[15-i];
        wait_hp();
        rxd[15-i] = spi_miso;
        spi_clk = ~mode[1];
        wait_hp();
        spi_clk = mode[1];
      end else begin
        spi_clk = ~mode[1];
        spi_mosi = tx[15-i];
        wait_hp();
        rxd[15-i] = spi_miso;
        spi_clk = mode[1];
        wait_hp();
      end
    end
    wait_hp();
    if (end_cs) begin
      spi_cs_n = 1'b1;
      wait_hp();
      wait_hp();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_miso", 32'(spi_miso), 32'h0);
    chk("rst_addr", 32'(reg_addr), 32'h0);
    chk("rst_data", 32'(reg_data_o), 32'h0);
    chk("rst_dv", 32'(reg_data_o_dv), 32'h0);
    rstb = 1'b1;
    ena  = 1'b1;
    wait_hp();

    // mode 0 write 0x83 / 0xA5
    d0 = dv_total;
    xfer(16'h83A5, 16, 1'b1, rx);
    chk("m0_addr", 32'(reg_addr), 32'h3);
    chk("m0_data", 32'(reg_data_o), 32'hA5);
    chk("m0_dv_cnt", 32'(dv_total - d0), 32'd1);
    chk("m0_dv_data", 32'(dv_data), 32'hA5);
    chk("m0_miso", 32'(rx), {16'h0, EXP_ST, 8'h3C});

    // mode 3 read 0x05
    mode = 2'b11;
    spi_clk = 1'b1;
    d0 = dv_total;
    xfer(16'h0500, 16, 1'b1, rx);
    chk("m3_rd_miso", 32'(rx), {16'h0, EXP_ST, 8'h3C});
    chk("m3_rd_addr", 32'(reg_addr), 32'h5);
    chk("m3_rd_no_dv", 32'(dv_total - d0), 32'd0);
    chk("m3_rd_data_kept", 32'(reg_data_o), 32'hA5);

    // mode 1 and mode 2 writes 0x8F / 0x01
    mode = 2'b01;
    spi_clk = 1'b0;
    d0 = dv_total;
    xfer(16'h8F01, 16, 1'b1, rx);
    chk("m1_addr", 32'(reg_addr), 32'hF);
    chk("m1_data", 32'(reg_data_o), 32'h01);
    chk("m1_dv_cnt", 32'(dv_total - d0), 32'd1);
    chk("m1_miso", 32'(rx), {16'h0, EXP_ST, 8'h3C});

    mode = 2'b10;
    spi_clk = 1'b1;
    d0 = dv_total;
    xfer(16'h8F01, 16, 1'b1, rx);
    chk("m2_addr", 32'(reg_addr), 32'hF);
    chk("m2_data", 32'(reg_data_o), 32'h01);
    chk("m2_dv_cnt", 32'(dv_total - d0), 32'd1);
    chk("m2_miso", 32'(rx), {16'h0, EXP_ST, 8'h3C});

    // abort after 12 bits of a write, then a clean write
    mode = 2'b00;
    spi_clk = 1'b0;
    d0 = dv_total;
    xfer(16'h84FF, 12, 1'b1, rx);
    chk("abort_no_dv", 32'(dv_total - d0), 32'd0);
    chk("abort_miso", 32'(spi_miso), 32'h0);
    chk("abort_addr", 32'(reg_addr), 32'h4);
    chk("abort_data_kept", 32'(reg_data_o), 32'h01);
    chk("abort_rx", 32'(rx), {16'h0, EXP_ST, 8'h30});
    d0 = dv_total;
    xfer(16'h827E, 16, 1'b1, rx);
    chk("post_abort_addr", 32'(reg_addr), 32'h2);
    chk("post_abort_data", 32'(reg_data_o), 32'h7E);
    chk("post_abort_dv", 32'(dv_total - d0), 32'd1);

    // enable low ignores a full frame
    ena = 1'b0;
    d0 = dv_total;
    m0 = miso_hi;
    xfer(16'h8155, 16, 1'b1, rx);
    chk("ena0_no_dv", 32'(dv_total - d0), 32'd0);
    chk("ena0_miso_quiet", 32'(miso_hi - m0), 32'd0);
    chk("ena0_addr", 32'(reg_addr), 32'h2);
    chk("ena0_data", 32'(reg_data_o), 32'h7E);
    ena = 1'b1;
    d0 = dv_total;
    xfer(16'h8155, 16, 1'b1, rx);
    chk("ena1_addr", 32'(reg_addr), 32'h1);
    chk("ena1_data", 32'(reg_data_o), 32'h55);
    chk("ena1_dv", 32'(dv_total - d0), 32'd1);

    // asynchronous reset in the middle of a frame
    d0 = dv_total;
    xfer(16'h86FF, 10, 1'b0, rx);
    chk("pre_rst_addr", 32'(reg_addr), 32'h6);
    rstb = 1'b0;
    #1;
    chk("arst_addr", 32'(reg_addr), 32'h0);
    chk("arst_data", 32'(reg_data_o), 32'h0);
    chk("arst_miso", 32'(spi_miso), 32'h0);
    wait_hp();
    rstb = 1'b1;
    wait_hp();
    spi_cs_n = 1'b1;
    wait_hp();
    chk("arst_no_dv", 32'(dv_total - d0), 32'd0);
    d0 = dv_total;
    xfer(16'h81C3, 16, 1'b1, rx);
    chk("post_rst_addr", 32'(reg_addr), 32'h1);
    chk("post_rst_data", 32'(reg_data_o), 32'hC3);
    chk("post_rst_dv", 32'(dv_total - d0), 32'd1);
    chk("post_rst_miso", 32'(rx), {16'h0, EXP_ST, 8'h3C});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
